jtopl_reg_wr: RTL and testbench
===============================

# jtopl_reg_wr

Register-write sequencer for the operator parameter ring: it receives host writes and delivers each one to the correct operator slot of the 18-stage circular shift register. It decodes the host address and waits for the target slot to reach the ring input. It then drives the field-select strobes, the three phase strobes (I, II, IV) and the data byte that the shift-register input mux consumes. It sits between the host bus interface and the operator CSR, and owns the slot counter that defines ring alignment.

## Interface
- LEN, 18, number of operator slots in the ring (slot counter modulus)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; ring advances one slot per cen cycle
- cpu_we  in  1  host write strobe, one clk wide
- cpu_a0  in  1  0 = address write, 1 = data write
- cpu_din  in  8  host data/address byte
- busy  out  1  write pending or in progress
- slot  out  5  current slot index, 0..LEN-1
- zero  out  1  high while slot==0
- dout  out  8  data byte to CSR input mux
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav  out  1 each  field selects
- update_op_I, update_op_II, update_op_IV  out  1 each  phase strobes

## Operation
- Address write (cpu_we & !cpu_a0): latch cpu_din into addr. Accepted in any state; does not disturb a transfer already in flight, which uses its own captured copy.
- Data write (cpu_we & cpu_a0), accepted only when state==IDLE at that clk edge:
  - Group from addr[7:5]: 1=mult, 2=ksl_tl, 3=ar_dr, 4=sl_rr, 7=wav. Any other group: write discarded, state unchanged.
  - Offset off=addr[4:0], g=off[4:3], s=off[2:0]. Valid only if g<3 and s<6; otherwise discarded.
  - Target slot t=6*g+s.
  - On a valid write, capture group, t and data, then go to WAIT.
- States: IDLE -> WAIT -> PH1 -> PH2 -> PH3 -> IDLE. All transitions out of WAIT are qualified by cen.
  - WAIT: on cen with slot==t -> PH1.
  - PH1 -> PH2 -> PH3 -> IDLE: one step per cen.
- Outputs are combinational from registered state:
  - update_op_I = WAIT & slot==t
  - update_op_II = PH1
  - update_op_IV = PH3
  - up_<grp> = (state!=IDLE) & captured group==grp; exactly one is high, or none in IDLE
  - dout = captured data, held constant from WAIT through PH3
  - busy = state!=IDLE
- Slot counter: increments on cen and wraps LEN-1 -> 0.
- Reset values: slot=0, zero=1, state=IDLE, busy=0, dout=0, addr=0, all strobes 0.
- Asynchronous reset mid-transfer aborts the transfer with no further strobes. The partially written slot is the CSR's concern.

## Timing
- Latency from the accepted data write to update_op_I: 0 to LEN-1 cen cycles.
- update_op_II follows update_op_I by exactly 1 cen; update_op_IV follows by exactly 3 cen.
- busy deasserts on the clk edge after the cen that ends PH3.
- Each strobe is valid for exactly one cen-qualified cycle and may stay high across non-cen clks.
- If a data write arrives on the same clk as the final PH3 cen, state is not yet IDLE, so the write is rejected (or buffered, see Configuration).
- If a data write arrives while slot==t already, it is captured to WAIT; the match occurs at the next visit of t, LEN cen later, or immediately if cen and slot==t are still true in the following cycle.

## Configuration
- JTOPL_REG_WR_BUF_EN:
  - Defined: a one-entry buffer holds a validated (group, t, data) that was accepted while busy. It launches into WAIT on the clk after returning to IDLE. A further write while the buffer is full is dropped. busy = (state!=IDLE) | buffer full.
  - Undefined: data writes while busy are dropped.

## Test plan
- Reset with rst=0 mid-WAIT -> all strobes 0, slot=0, busy=0 immediately, without waiting for a clk edge.
- Address 0x20, then data 0xA5 at slot=5 (t=0) -> busy=1; update_op_I when slot==0, II when slot==1, IV when slot==3; up_mult=1 and dout=0xA5 throughout; busy=0 afterwards.
- Address 0x55 (g=2, s=5, t=17), data 0x3F -> up_ksl_tl=1; update_op_I at slot 17, II at slot 0 (wrap), IV at slot 2.
- Address 0x26 (s=6) or 0xA0 (group 5), then a data write -> no strobes, busy stays 0.
- Two data writes 0x11 then 0x22, 3 cen apart, to address 0xE1 -> without the macro only 0x11 is delivered (up_wav); with JTOPL_REG_WR_BUF_EN 0x22 follows in a second full I/II/IV sequence.
- cen held low for 100 clk in WAIT -> slot frozen, no state change; sequence resumes correctly once cen returns.

Source files
------------

// File: rtl/jtopl_reg_wr.sv
// Host write sequencer for the 18-slot operator ring: decodes address, waits for target slot, emits I/II/IV strobes.
// Optional JTOPL_REG_WR_BUF_EN: one-entry buffer for a data write accepted while busy.
module jtopl_reg_wr #(
  parameter int LEN = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cpu_we,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_din,
  output logic       busy,
  output logic [4:0] slot,
  output logic       zero,
  output logic [7:0] dout,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_wav,
  output logic       update_op_I,
  output logic       update_op_II,
  output logic       update_op_IV
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PH1, S_PH2, S_PH3} state_t;

  localparam logic [4:0] LAST_SLOT = 5'(LEN - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_slot;
  logic [7:0]  r_addr;
  logic [2:0]  r_grp;
  logic [4:0]  r_tgt;
  logic [7:0]  r_dat;

  logic        w_dwr, w_awr, w_idle;
  logic [2:0]  w_grp;
  logic [1:0]  w_g;
  logic [2:0]  w_s;
  logic [4:0]  w_tgt;
  logic        w_grp_ok, w_valid, w_take;
  logic        w_launch_buf;
  logic [2:0]  w_buf_grp;
  logic [4:0]  w_buf_tgt;
  logic [7:0]  w_buf_dat;
  logic        w_slot_hit;

  assign w_dwr    = cpu_we & cpu_a0;
  assign w_awr    = cpu_we & ~cpu_a0;
  assign w_idle   = (r_state == S_IDLE);
  assign w_grp    = r_addr[7:5];
  assign w_g      = r_addr[4:3];
  assign w_s      = r_addr[2:0];
  // t = 6*g + s, built from shifts so the width stays 5 bits throughout
  assign w_tgt    = ({3'b000, w_g} << 2) + ({3'b000, w_g} << 1) + {2'b00, w_s};
  assign w_grp_ok = (w_grp == 3'd1) | (w_grp == 3'd2) | (w_grp == 3'd3) |
                    (w_grp == 3'd4) | (w_grp == 3'd7);
  assign w_valid  = w_dwr & w_grp_ok & (w_g != 2'd3) & (w_s < 3'd6);
  assign w_slot_hit = (r_slot == r_tgt);

`ifdef JTOPL_REG_WR_BUF_EN
  logic       r_buf_vld;
  logic [2:0] r_buf_grp;
  logic [4:0] r_buf_tgt;
  logic [7:0] r_buf_dat;

  // A buffered entry has priority; a direct write in that same IDLE cycle is dropped.
  assign w_launch_buf = w_idle & r_buf_vld;
  assign w_take       = w_valid & w_idle & ~r_buf_vld;
  assign w_buf_grp    = r_buf_grp;
  assign w_buf_tgt    = r_buf_tgt;
  assign w_buf_dat    = r_buf_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_vld <= 1'b0;
      r_buf_grp <= 3'd0;
      r_buf_tgt <= 5'd0;
      r_buf_dat <= 8'd0;
    end else if (w_launch_buf) begin
      r_buf_vld <= 1'b0;
    end else if (w_valid & ~w_idle & ~r_buf_vld) begin
      r_buf_vld <= 1'b1;
      r_buf_grp <= w_grp;
      r_buf_tgt <= w_tgt;
      r_buf_dat <= cpu_din;
    end
  end

  assign busy = ~w_idle | r_buf_vld;
`else
  assign w_launch_buf = 1'b0;
  assign w_take       = w_valid & w_idle;
  assign w_buf_grp    = 3'd0;
  assign w_buf_tgt    = 5'd0;
  assign w_buf_dat    = 8'd0;
  assign busy         = ~w_idle;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= 5'd0;
    end else if (cen) begin
      r_slot <= (r_slot == LAST_SLOT) ? 5'd0 : r_slot + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= 8'd0;
    end else if (w_awr) begin
      r_addr <= cpu_din;
    end
  end

  // In-flight transfer keeps its own copy so later address writes cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grp <= 3'd0;
      r_tgt <= 5'd0;
      r_dat <= 8'd0;
    end else if (w_launch_buf) begin
      r_grp <= w_buf_grp;
      r_tgt <= w_buf_tgt;
      r_dat <= w_buf_dat;
    end else if (w_take) begin
      r_grp <= w_grp;
      r_tgt <= w_tgt;
      r_dat <= cpu_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_launch_buf | w_take) w_state_nxt = S_WAIT;
      S_WAIT: if (cen & w_slot_hit)      w_state_nxt = S_PH1;
      S_PH1:  if (cen)                   w_state_nxt = S_PH2;
      S_PH2:  if (cen)                   w_state_nxt = S_PH3;
      S_PH3:  if (cen)                   w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    update_op_I  = (r_state == S_WAIT) & w_slot_hit;
    update_op_II = (r_state == S_PH1);
    update_op_IV = (r_state == S_PH3);
    up_mult      = ~w_idle & (r_grp == 3'd1);
    up_ksl_tl    = ~w_idle & (r_grp == 3'd2);
    up_ar_dr     = ~w_idle & (r_grp == 3'd3);
    up_sl_rr     = ~w_idle & (r_grp == 3'd4);
    up_wav       = ~w_idle & (r_grp == 3'd7);
    dout         = r_dat;
    slot         = r_slot;
    zero         = (r_slot == 5'd0);
  end

endmodule

// File: tb/tb_jtopl_reg_wr.sv
// Directed self-checking bench for jtopl_reg_wr; honours JTOPL_REG_WR_BUF_EN when defined.
module tb_jtopl_reg_wr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen = 1'b1;
  logic       cpu_we = 1'b0;
  logic       cpu_a0 = 1'b0;
  logic [7:0] cpu_din = 8'd0;
  logic       busy, zero;
  logic [4:0] slot;
  logic [7:0] dout;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
  logic       update_op_I, update_op_II, update_op_IV;

  int total = 0;
  int bad   = 0;

  jtopl_reg_wr #(.LEN(18)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .cpu_we(cpu_we), .cpu_a0(cpu_a0), .cpu_din(cpu_din),
    .busy(busy), .slot(slot), .zero(zero), .dout(dout),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
    .up_sl_rr(up_sl_rr), .up_wav(up_wav),
    .update_op_I(update_op_I), .update_op_II(update_op_II), .update_op_IV(update_op_IV)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    cpu_we = 1'b1; cpu_a0 = a0; cpu_din = d;
    step();
    cpu_we = 1'b0; cpu_a0 = 1'b0; cpu_din = 8'd0;
  endtask

  task automatic wait_slot(input logic [4:0] n);
    for (int i = 0; i < 40 && slot != n; i++) step();
    chk("slot_reach", 32'(slot), 32'(n));
  endtask

  initial begin
    logic acc;
    // reset state
    #2;
    chk("rst_slot", 32'(slot), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_strobes", {29'd0, update_op_I, update_op_II, update_op_IV}, 0);
    chk("rst_up", {27'd0, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, 0);
    #10 rst = 1'b1;
    step();

    // mult, t=0, data written at slot 5
    wr(1'b0, 8'h20);
    wait_slot(5'd5);
    wr(1'b1, 8'hA5);
    chk("m_busy", 32'(busy), 1);
    chk("m_up", 32'(up_mult), 1);
    chk("m_dout", 32'(dout), 32'hA5);
    chk("m_I_early", 32'(update_op_I), 0);
    wait_slot(5'd0);
    chk("m_I", 32'(update_op_I), 1);
    chk("m_zero", 32'(zero), 1);
    step();
    chk("m_II", {30'd0, update_op_I, update_op_II}, 1);
    step();
    chk("m_ph2", {30'd0, update_op_II, update_op_IV}, 0);
    step();
    chk("m_slot3", 32'(slot), 3);
    chk("m_IV", 32'(update_op_IV), 1);
    chk("m_dout_hold", 32'(dout), 32'hA5);
    chk("m_up_hold", 32'(up_mult), 1);
    step();
    chk("m_done_busy", 32'(busy), 0);
    chk("m_done_up", 32'(up_mult), 0);

    // ksl_tl, t=17, wrap
    wr(1'b0, 8'h55);
    wr(1'b1, 8'h3F);
    wait_slot(5'd17);
    chk("k_I", 32'(update_op_I), 1);
    chk("k_up", {27'd0, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, 32'b01000);
    chk("k_dout", 32'(dout), 32'h3F);
    step();
    chk("k_II_slot", 32'(slot), 0);
    chk("k_II", 32'(update_op_II), 1);
    step();
    step();
    chk("k_IV", 32'(update_op_IV), 1);
    step();
    chk("k_done", 32'(busy), 0);

    // invalid offset and invalid group
    wr(1'b0, 8'h26);
    wr(1'b1, 8'h99);
    wr(1'b0, 8'hA0);
    wr(1'b1, 8'h98);
    acc = 1'b0;
    repeat (20) begin
      step();
      acc = acc | busy | update_op_I | update_op_II | update_op_IV;
    end
    chk("inv_quiet", 32'(acc), 0);

    // two writes to wav t=1, 3 cen apart
    wr(1'b0, 8'hE1);
    wait_slot(5'd5);
    wr(1'b1, 8'h11);
    step();
    step();
    wr(1'b1, 8'h22);
    wait_slot(5'd1);
    chk("w1_I", 32'(update_op_I), 1);
    chk("w1_up", {27'd0, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, 32'b00001);
    chk("w1_dout", 32'(dout), 32'h11);
    step();
    step();
    step();
    chk("w1_IV", 32'(update_op_IV), 1);
    step();
`ifdef JTOPL_REG_WR_BUF_EN
    chk("w2_buf_busy", 32'(busy), 1);
    wait_slot(5'd1);
    chk("w2_I", 32'(update_op_I), 1);
    chk("w2_dout", 32'(dout), 32'h22);
    chk("w2_up", 32'(up_wav), 1);
    step();
    chk("w2_II", 32'(update_op_II), 1);
    step();
    step();
    chk("w2_IV", 32'(update_op_IV), 1);
    step();
    chk("w2_done", 32'(busy), 0);
`else
    chk("w2_busy", 32'(busy), 0);
    acc = 1'b0;
    repeat (20) begin
      step();
      acc = acc | busy | update_op_I;
    end
    chk("w2_dropped", 32'(acc), 0);
`endif

    // cen stall in WAIT
    wr(1'b0, 8'h20);
    wait_slot(5'd10);
    wr(1'b1, 8'h77);
    cen = 1'b0;
    repeat (100) step();
    chk("st_slot", 32'(slot), 11);
    chk("st_busy", 32'(busy), 1);
    chk("st_I", 32'(update_op_I), 0);
    cen = 1'b1;
    wait_slot(5'd0);
    chk("st_I_hit", 32'(update_op_I), 1);
    cen = 1'b0;
    repeat (3) step();
    chk("st_I_hold", 32'(update_op_I), 1);
    chk("st_slot0", 32'(slot), 0);
    cen = 1'b1;
    step();
    chk("st_II", 32'(update_op_II), 1);
    chk("st_dout", 32'(dout), 32'h77);
    step();
    step();
    chk("st_IV", 32'(update_op_IV), 1);
    step();
    chk("st_done", 32'(busy), 0);

    // async reset mid-WAIT
    wr(1'b0, 8'h55);
    wr(1'b1, 8'h5A);
    step();
    chk("ar_pre_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_slot", 32'(slot), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_dout", 32'(dout), 0);
    chk("ar_strobes", {29'd0, update_op_I, update_op_II, update_op_IV}, 0);
    chk("ar_up", {27'd0, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
